// File: rtl/cswap_pipe_if.sv
// Handshake/data bundle for cswap_pipe: input beat (a, b, swap, mode) and
// output beat (aswap, bswap), each with its own valid/ready pair.
interface cswap_pipe_if #(
  parameter int unsigned WID   = 256,
  parameter int unsigned NLANE = 1
);
  localparam int unsigned DW = NLANE * WID;

  logic             in_vld;
  logic             in_rdy;
  logic             mode;
  logic [NLANE-1:0] swap;
  logic [DW-1:0]    a;
  logic [DW-1:0]    b;
  logic             out_vld;
  logic             out_rdy;
  logic [DW-1:0]    aswap;
  logic [DW-1:0]    bswap;
  logic             busy;

  // Upstream/downstream agent side
  modport master (
    output in_vld, mode, swap, a, b, out_rdy,
    input  in_rdy, out_vld, aswap, bswap, busy
  );

  // Pipeline side
  modport slave (
    input  in_vld, mode, swap, a, b, out_rdy,
    output in_rdy, out_vld, aswap, bswap, busy
  );
endinterface

// File: rtl/cswap_pipe.sv
// Two-stage constant-time conditional swap/move over NLANE lanes of WID bits.
// Optional CSWAP_PIPE_ZEROIZE_EN: wipe a stage's data/mask when it goes empty.
module cswap_pipe #(
  parameter int unsigned WID   = 256,
  parameter int unsigned NLANE = 1
) (
  input logic         clk,
  input logic         rst,
  cswap_pipe_if.slave io
);
  localparam int unsigned DW = NLANE * WID;

  logic          s1_vld;
  logic          s1_mode;
  logic [DW-1:0] s1_a;
  logic [DW-1:0] s1_b;
  logic [DW-1:0] s1_mask;

  logic          s2_vld;
  logic [DW-1:0] s2_a;
  logic [DW-1:0] s2_b;

  logic          rdy_c;
  logic          accept_c;
  logic          s1_adv_c;
  logic          pop_c;
  logic [DW-1:0] in_mask_c;
  logic [DW-1:0] ab_x_c;
  logic [DW-1:0] s2_a_nxt_c;
  logic [DW-1:0] s2_b_nxt_c;

  // Handshake control
  assign rdy_c    = ~s1_vld | ~s2_vld | io.out_rdy;
  assign accept_c = io.in_vld & rdy_c;
  assign s1_adv_c = s1_vld & (~s2_vld | io.out_rdy);
  assign pop_c    = s2_vld & io.out_rdy;

  // Per-lane mask: all-ones copy of swap bit ANDed with a^b; no data-driven select
  assign ab_x_c = io.a ^ io.b;
  always_comb begin
    in_mask_c = '0;
    for (int unsigned i = 0; i < NLANE; i++) begin
      in_mask_c[i*WID +: WID] = {WID{io.swap[i]}} & ab_x_c[i*WID +: WID];
    end
  end

  // Move mode suppresses the b-side flip by masking, not by selecting
  assign s2_a_nxt_c = s1_a ^ s1_mask;
  assign s2_b_nxt_c = s1_b ^ (s1_mask & {DW{~s1_mode}});

  // Stage 1: operands and mask
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_mode <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_mask <= '0;
    end else if (accept_c) begin
      s1_vld  <= 1'b1;
      s1_mode <= io.mode;
      s1_a    <= io.a;
      s1_b    <= io.b;
      s1_mask <= in_mask_c;
    end else if (s1_adv_c) begin
      s1_vld  <= 1'b0;
`ifdef CSWAP_PIPE_ZEROIZE_EN
      s1_mode <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_mask <= '0;
`endif
    end
  end

  // Stage 2: results, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld <= 1'b0;
      s2_a   <= '0;
      s2_b   <= '0;
    end else if (s1_adv_c) begin
      s2_vld <= 1'b1;
      s2_a   <= s2_a_nxt_c;
      s2_b   <= s2_b_nxt_c;
    end else if (pop_c) begin
      s2_vld <= 1'b0;
`ifdef CSWAP_PIPE_ZEROIZE_EN
      s2_a   <= '0;
      s2_b   <= '0;
`endif
    end
  end

  assign io.in_rdy  = rdy_c;
  assign io.out_vld = s2_vld;
  assign io.aswap   = s2_a;
  assign io.bswap   = s2_b;
  assign io.busy    = s1_vld | s2_vld;
endmodule

// File: tb/tb_cswap_pipe.sv
// Scoreboard bench for cswap_pipe: directed corner cases plus random traffic
// with random backpressure, checked against a per-lane swap/move model.
module tb_cswap_pipe;
  localparam int unsigned WID   = 8;
  localparam int unsigned NLANE = 2;
  localparam int unsigned DW    = NLANE * WID;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  cswap_pipe_if #(.WID(WID), .NLANE(NLANE)) bus ();

  cswap_pipe #(.WID(WID), .NLANE(NLANE)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  exp_t          exp_q[$];
  int            n_chk = 0;
  int            n_err = 0;
  int            n_out = 0;
  bit            acc   = 1'b0;
  bit            hold  = 1'b0;
  logic [DW-1:0] pa, pb;

  // Reference: swap exchanges the lane values, move copies b into a
  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [NLANE-1:0] sw, input logic md);
    exp_t e;
    e.a = a;
    e.b = b;
    for (int i = 0; i < NLANE; i++) begin
      if (sw[i]) begin
        e.a[i*WID +: WID] = b[i*WID +: WID];
        if (!md) e.b[i*WID +: WID] = a[i*WID +: WID];
      end
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One clock: note acceptance at the negedge, return just after the posedge
  task automatic tick();
    @(negedge clk);
    acc = !rst && bus.in_vld && bus.in_rdy;
    if (acc) exp_q.push_back(model(bus.a, bus.b, bus.swap, bus.mode));
    @(posedge clk);
    #1;
  endtask

  task automatic drive_hold(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [NLANE-1:0] sw, input logic md, output int cyc);
    bus.in_vld = 1'b1;
    bus.a      = a;
    bus.b      = b;
    bus.swap   = sw;
    bus.mode   = md;
    cyc        = 0;
    do begin
      tick();
      cyc++;
    end while (!acc && cyc < 50);
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  // Monitor: pops expectations on each output transfer, checks stall stability
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_vld", 32'(bus.out_vld), 32'd1);
        chk("hold_a", 32'(bus.aswap), 32'(pa));
        chk("hold_b", 32'(bus.bswap), 32'(pb));
      end
      if (bus.out_vld && bus.out_rdy) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_out: got a=%h b=%h want no beat", bus.aswap, bus.bswap);
        end else begin
          e = exp_q.pop_front();
          chk("out_a", 32'(bus.aswap), 32'(e.a));
          chk("out_b", 32'(bus.bswap), 32'(e.b));
          n_out++;
        end
      end
      hold = bus.out_vld && !bus.out_rdy;
      pa   = bus.aswap;
      pb   = bus.bswap;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int total;
    int n0;
    rst         = 1'b1;
    bus.in_vld  = 1'b0;
    bus.mode    = 1'b0;
    bus.swap    = '0;
    bus.a       = '0;
    bus.b       = '0;
    bus.out_rdy = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("rst_aswap", 32'(bus.aswap), 32'd0);
    chk("rst_bswap", 32'(bus.bswap), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_rdy", 32'(bus.in_rdy), 32'd1);
    rst = 1'b0;

    // Lane 0 swap 0x5A/0xC3, lane 1 untouched; two-cycle latency
    drive_hold(16'h115A, 16'h22C3, 2'b01, 1'b0, cyc);
    chk("first_accept_cyc", 32'(cyc), 32'd1);
    bus.in_vld = 1'b0;
    chk("lat1_out_vld", 32'(bus.out_vld), 32'd0);
    chk("lat1_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("lat2_out_vld", 32'(bus.out_vld), 32'd1);
    chk("ex1_aswap", 32'(bus.aswap), 32'h11C3);
    chk("ex1_bswap", 32'(bus.bswap), 32'h225A);
    tick();

    // Move mode on lane 0 only
    drive_hold(16'h1122, 16'h3344, 2'b01, 1'b1, cyc);
    bus.in_vld = 1'b0;
    tick();
    chk("ex2_aswap", 32'(bus.aswap), 32'h1144);
    chk("ex2_bswap", 32'(bus.bswap), 32'h3344);
    tick();
    tick();

    // Stage data after a single beat drains
    drive_hold(16'hFFFF, 16'h0000, 2'b11, 1'b0, cyc);
    bus.in_vld = 1'b0;
    tick();
    tick();
    chk("drained_out_vld", 32'(bus.out_vld), 32'd0);
    chk("drained_busy", 32'(bus.busy), 32'd0);
`ifdef CSWAP_PIPE_ZEROIZE_EN
    chk("zz_s1_a", 32'(dut.s1_a), 32'h0000);
    chk("zz_s1_mask", 32'(dut.s1_mask), 32'h0000);
    chk("zz_s2_b", 32'(dut.s2_b), 32'h0000);
`else
    chk("keep_s1_a", 32'(dut.s1_a), 32'hFFFF);
    chk("keep_s1_mask", 32'(dut.s1_mask), 32'hFFFF);
    chk("keep_s2_b", 32'(dut.s2_b), 32'hFFFF);
`endif

    // Backpressure: two beats fill the pipe, third is refused, outputs hold
    bus.out_rdy = 1'b0;
    drive_hold(16'h0101, 16'h1010, 2'b10, 1'b0, cyc);
    drive_hold(16'h0202, 16'h2020, 2'b11, 1'b1, cyc);
    chk("full_in_rdy", 32'(bus.in_rdy), 32'd0);
    chk("full_out_vld", 32'(bus.out_vld), 32'd1);
    chk("full_busy", 32'(bus.busy), 32'd1);
    bus.a    = 16'h0303;
    bus.b    = 16'h3030;
    bus.swap = 2'b01;
    bus.mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_no_accept", 32'(acc), 32'd0);
    end
    n0 = n_out;
    bus.out_rdy = 1'b1;
    drive_hold(16'h0303, 16'h3030, 2'b01, 1'b0, cyc);
    chk("resume_b3_cyc", 32'(cyc), 32'd1);
    drive_hold(16'h0404, 16'h4040, 2'b00, 1'b0, cyc);
    chk("resume_b4_cyc", 32'(cyc), 32'd1);
    bus.in_vld = 1'b0;
    tick();
    tick();
    chk("resume_drained", 32'(n_out - n0), 32'd4);
    tick();
    tick();

    // Full throughput
    total = 0;
    for (int i = 0; i < 20; i++) begin
      drive_hold(DW'($urandom), DW'($urandom), NLANE'($urandom), 1'($urandom), cyc);
      total += cyc;
    end
    bus.in_vld = 1'b0;
    chk("throughput_cycles", 32'(total), 32'd20);
    repeat (4) tick();

    // Reset with two beats in flight; in_vld during reset is ignored
    drive_hold(16'hAAAA, 16'h5555, 2'b11, 1'b0, cyc);
    drive_hold(16'h1234, 16'h5678, 2'b10, 1'b1, cyc);
    rst = 1'b1;
    exp_q.delete();
    bus.a = 16'hBEEF;
    tick();
    rst        = 1'b0;
    bus.in_vld = 1'b0;
    chk("midrst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_in_rdy", 32'(bus.in_rdy), 32'd1);
    repeat (3) tick();
    chk("postrst_out_vld", 32'(bus.out_vld), 32'd0);

    // Random traffic with random backpressure
    acc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!bus.in_vld || acc) begin
        if ($urandom_range(3) != 0) begin
          bus.in_vld = 1'b1;
          bus.a      = DW'($urandom);
          bus.b      = DW'($urandom);
          bus.swap   = NLANE'($urandom);
          bus.mode   = 1'($urandom);
        end else begin
          bus.in_vld = 1'b0;
        end
      end
      bus.out_rdy = ($urandom_range(3) != 0);
      tick();
    end
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b1;
    repeat (6) tick();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_busy", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cswap_pipe.md
CSWAP_PIPE -- requirements
Module: cswap_pipe

Interface
REQ-001 SHALL provide parameter WID, default 256, meaning operand width in bits per lane.
REQ-002 SHALL provide parameter NLANE, default 1, meaning number of independent a/b swap lanes processed per beat.
REQ-003 SHALL provide port clk  input  1  clock; reset rst, synchronous, active-high.
REQ-004 SHALL provide port rst  input  1  synchronous active-high reset.
REQ-005 SHALL provide port in_vld  input  1  input beat valid.
REQ-006 SHALL provide port in_rdy  output  1  block can accept an input beat this cycle.
REQ-007 SHALL provide port mode  input  1  0 = conditional swap, 1 = conditional move (a takes b, b unchanged).
REQ-008 SHALL provide port swap  input  NLANE  per-lane condition bit, lane i uses swap[i].
REQ-009 SHALL provide port a  input  NLANE*WID  lane i at bits [i*WID +: WID].
REQ-010 SHALL provide port b  input  NLANE*WID  same packing as a.
REQ-011 SHALL provide port out_vld  output  1  output beat valid.
REQ-012 SHALL provide port out_rdy  input  1  downstream accepts output beat.
REQ-013 SHALL provide port aswap  output  NLANE*WID  result a per lane.
REQ-014 SHALL provide port bswap  output  NLANE*WID  result b per lane.
REQ-015 SHALL provide port busy  output  1  high while any stage holds a valid beat.

Function
REQ-016 SHALL implement two pipeline stages: S1 registers a, b, mode and mask_i = {WID{swap[i]}} & (a_i ^ b_i); S2 registers results.
REQ-017 SHALL compute in S2: aswap_i = a_i ^ mask_i; bswap_i = mode ? b_i : b_i ^ mask_i.
REQ-018 SHALL use only XOR/AND masking on data; no data-dependent mux select, no data-dependent timing.
REQ-019 SHALL accept a beat when in_vld & in_rdy; latency 2 cycles from acceptance to out_vld with out_rdy held high.
REQ-020 SHALL drive in_rdy = !s1_vld | !s2_vld | out_rdy (combinational, no dependence on in_vld).
REQ-021 SHALL advance S1->S2 when s1_vld & (!s2_vld | out_rdy); S2 clears valid when out_vld & out_rdy and no S1 advance.
REQ-022 SHALL sustain one beat per cycle with in_vld and out_rdy continuously high.
REQ-023 SHALL hold aswap, bswap, out_vld stable while out_vld & !out_rdy.
REQ-024 SHALL, when both stages full and out_rdy low, deassert in_rdy and keep S1 contents unchanged.
REQ-025 SHALL handle simultaneous accept and output pop in one cycle without loss or duplication.
REQ-026 SHALL drive busy = s1_vld | s2_vld.
REQ-027 SHALL preserve beat order; lanes are independent and processed in the same beat.

Reset
REQ-028 SHALL on rst clear s1_vld, s2_vld and all data/mask registers to 0; out_vld=0, aswap=0, bswap=0, busy=0, in_rdy=1 in the cycle after rst.
REQ-029 SHALL discard in-flight beats when rst asserts mid-operation; no out_vld for them after rst releases.
REQ-030 SHALL ignore in_vld while rst is high.

Configuration
REQ-031 SHALL support macro CSWAP_PIPE_ZEROIZE_EN.
REQ-032 With CSWAP_PIPE_ZEROIZE_EN defined, SHALL clear a stage's data and mask registers to 0 in any cycle that stage becomes invalid (bubble or pop without refill), so no stale secret remains.
REQ-033 Without CSWAP_PIPE_ZEROIZE_EN, SHALL leave data registers unchanged when a stage becomes invalid; only valid flags clear.

Verification
REQ-034 WID=8, NLANE=1: a=0x5A, b=0xC3, swap=1, mode=0, out_rdy=1 -> 2 cycles later out_vld=1, aswap=0xC3, bswap=0x5A.
REQ-035 WID=8, NLANE=2: a={0x11,0x22}, b={0x33,0x44}, swap=2'b01, mode=1 -> aswap={0x11,0x44}, bswap={0x33,0x44}.
REQ-036 Back-to-back 4 beats, out_rdy=0 from cycle 1 -> in_rdy low after 2 accepted beats, outputs held; out_rdy=1 -> all 4 emerge in order, one per cycle.
REQ-037 rst pulsed 1 cycle with 2 beats in flight -> out_vld stays 0, busy=0, in_rdy=1 next cycle.
REQ-038 CSWAP_PIPE_ZEROIZE_EN defined: single beat a=0xFF, b=0x00, swap=1 popped -> next cycle S1/S2 data registers read 0; undefined: registers retain prior values.
